// File: rtl/uart_send_stage.sv
// UART transmit output stage: byte FIFO fed by out-instructions, drained over valid/ready.
// Optional 4-byte word push (MSB first) enabled by defining UART_SEND_WORD_EN.
module uart_send_stage #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegtoUART,
  input  logic                     send_word,
  input  logic [31:0]              write_data,
  input  logic                     output_ready,
  output logic [7:0]               output_data,
  output logic                     output_valid,
  output logic                     pc_enable,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;
  localparam int CW    = N + 1;

  typedef logic [N-1:0]  ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;

  cnt_t       need;
  cnt_t       free;
  logic       accept;
  logic       pop;
  ptr_t       rd_next;

`ifndef UART_SEND_WORD_EN
  logic unused_word_in;
  assign unused_word_in = ^{send_word, write_data[31:8]};
`endif

  // Request sizing, admission and core stall; free uses the pre-pop count.
  always_comb begin
    need = cnt_t'(1);
`ifdef UART_SEND_WORD_EN
    if (send_word) need = cnt_t'(4);
`endif
    free      = cnt_t'(DEPTH) - count_q;
    accept    = RegtoUART && !reset && (free >= need);
    pc_enable = !reset && (!RegtoUART || accept);
    pop       = out_valid_q && output_ready;
  end

  // FIFO storage writes and pointer/count updates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) begin
`ifdef UART_SEND_WORD_EN
      if (send_word) begin
        for (int i = 0; i < 4; i++) begin
          mem_d[wr_ptr_q + ptr_t'(i)] = write_data[8*(3-i) +: 8];
        end
      end else begin
        mem_d[wr_ptr_q] = write_data[7:0];
      end
`else
      mem_d[wr_ptr_q] = write_data[7:0];
`endif
      wr_ptr_d = wr_ptr_q + ptr_t'(need);
    end
    rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d  = count_q + (accept ? need : cnt_t'(0))
                       - (pop ? cnt_t'(1) : cnt_t'(0));
  end

  // Output register: advance on pop, load when idle, hold while stalled.
  always_comb begin
    rd_next     = rd_ptr_q + ptr_t'(1);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = (count_q != cnt_t'(1));
      if (count_q != cnt_t'(1)) out_data_d = mem_q[rd_next];
    end else if (!out_valid_q && count_q != cnt_t'(0)) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Byte storage; contents are only read when counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign output_data  = out_data_q;
  assign output_valid = out_valid_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_send_stage.sv
// Directed self-checking bench for uart_send_stage.
// Word scenario runs only when UART_SEND_WORD_EN is defined.
module tb_uart_send_stage;

  logic        clk;
  logic        reset;
  logic        RegtoUART;
  logic        send_word;
  logic [31:0] write_data;
  logic        output_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        pc_enable;
  logic [3:0]  fifo_count;

  int errors;
  int checks;

  uart_send_stage #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .RegtoUART    (RegtoUART),
    .send_word    (send_word),
    .write_data   (write_data),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .pc_enable    (pc_enable),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_pc_en_hi got=%b exp=0", pc_enable);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (output_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0", output_valid);
    end
    checks++;
    if (output_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got=%h exp=00", output_data);
    end
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL rst_count got=%0d exp=0", fifo_count);
    end
    checks++;
    if (pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL rst_pc_en got=%b exp=1", pc_enable);
    end
  endtask

  task automatic test_single();
    output_ready = 1'b1;
    RegtoUART    = 1'b1;
    write_data   = 32'h0000_0041;
    #1;
    checks++;
    if (pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_pc_en got=%b exp=1", pc_enable);
    end
    tick();
    RegtoUART = 1'b0;
    checks++;
    if (fifo_count !== 4'd1 || output_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_push got cnt=%0d v=%b exp cnt=1 v=0",
               fifo_count, output_valid);
    end
    tick();
    checks++;
    if (output_valid !== 1'b1 || output_data !== 8'h41) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h exp v=1 d=41",
               output_valid, output_data);
    end
    tick();
    checks++;
    if (fifo_count !== 4'd0 || output_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got cnt=%0d v=%b exp cnt=0 v=0",
               fifo_count, output_valid);
    end
  endtask

  task automatic test_fill_stall();
    output_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      RegtoUART  = 1'b1;
      write_data = 32'(i);
      #1;
      checks++;
      if (pc_enable !== 1'b1) begin
        errors++;
        $display("FAIL fill_pc_en i=%0d got=%b exp=1", i, pc_enable);
      end
      tick();
    end
    write_data = 32'h0000_0009;
    #1;
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_count got=%0d exp=8", fifo_count);
    end
    checks++;
    if (pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL full_stall got=%b exp=0", pc_enable);
    end
    checks++;
    if (output_valid !== 1'b1 || output_data !== 8'h01) begin
      errors++;
      $display("FAIL full_head got v=%b d=%h exp v=1 d=01",
               output_valid, output_data);
    end
    tick();
    checks++;
    if (fifo_count !== 4'd8 || pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got cnt=%0d pe=%b exp cnt=8 pe=0",
               fifo_count, pc_enable);
    end
  endtask

  task automatic test_full_push_pop();
    output_ready = 1'b1;
    #1;
    checks++;
    if (pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL nobypass_pc_en got=%b exp=0", pc_enable);
    end
    tick();
    output_ready = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 4'd7 || pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL after_pop got cnt=%0d pe=%b exp cnt=7 pe=1",
               fifo_count, pc_enable);
    end
    tick();
    RegtoUART = 1'b0;
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL retry_push got=%0d exp=8", fifo_count);
    end
    output_ready = 1'b1;
    for (int e = 2; e <= 9; e++) begin
      checks++;
      if (output_valid !== 1'b1 || output_data !== 8'(e)) begin
        errors++;
        $display("FAIL drain_order got v=%b d=%h exp v=1 d=%h",
                 output_valid, output_data, 8'(e));
      end
      tick();
    end
    output_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || output_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got cnt=%0d v=%b exp cnt=0 v=0",
               fifo_count, output_valid);
    end
  endtask

`ifdef UART_SEND_WORD_EN
  task automatic test_word_wrap();
    logic [7:0] exp_b [8];
    exp_b = '{8'h12, 8'h13, 8'h14, 8'h15,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
    output_ready = 1'b0;
    send_word    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RegtoUART  = 1'b1;
      write_data = 32'h11 + 32'(i);
      tick();
    end
    RegtoUART  = 1'b1;
    send_word  = 1'b1;
    write_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (fifo_count !== 4'd5 || pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL word_stall got cnt=%0d pe=%b exp cnt=5 pe=0",
               fifo_count, pc_enable);
    end
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 4'd4 || pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL word_room got cnt=%0d pe=%b exp cnt=4 pe=1",
               fifo_count, pc_enable);
    end
    tick();
    RegtoUART = 1'b0;
    send_word = 1'b0;
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL word_push got=%0d exp=8", fifo_count);
    end
    output_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (output_valid !== 1'b1 || output_data !== exp_b[j]) begin
        errors++;
        $display("FAIL word_order j=%0d got v=%b d=%h exp d=%h",
                 j, output_valid, output_data, exp_b[j]);
      end
      tick();
    end
    output_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    output_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RegtoUART  = 1'b1;
      write_data = 32'hA1 + 32'(i);
      tick();
    end
    RegtoUART = 1'b0;
    checks++;
    if (fifo_count !== 4'd5) begin
      errors++;
      $display("FAIL mid_queued got=%0d exp=5", fifo_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_pc_en got=%b exp=0", pc_enable);
    end
    tick();
    checks++;
    if (fifo_count !== 4'd0 || output_valid !== 1'b0 ||
        output_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst got cnt=%0d v=%b d=%h exp 0 0 00",
               fifo_count, output_valid, output_data);
    end
    reset        = 1'b0;
    output_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (output_valid !== 1'b0 || fifo_count !== 4'd0) begin
        errors++;
        $display("FAIL stale k=%0d got v=%b cnt=%0d exp v=0 cnt=0",
                 k, output_valid, fifo_count);
      end
    end
    RegtoUART  = 1'b1;
    write_data = 32'h0000_005A;
    tick();
    RegtoUART = 1'b0;
    tick();
    checks++;
    if (output_valid !== 1'b1 || output_data !== 8'h5A) begin
      errors++;
      $display("FAIL post_rst got v=%b d=%h exp v=1 d=5a",
               output_valid, output_data);
    end
    tick();
    output_ready = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    RegtoUART    = 1'b0;
    send_word    = 1'b0;
    write_data   = 32'h0;
    output_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_stall();
    test_full_push_pop();
`ifdef UART_SEND_WORD_EN
    test_word_wrap();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
